// File: rtl/hsv_core_commit_order_if.sv
// Bundle between the execution units and the in-order commit stage.
// The core side uses the slave modport; the unit/regfile side uses master.
interface hsv_core_commit_order_if #(
  parameter int NUM_UNITS = 5,
  parameter int TOKEN_W   = 8,
  parameter int DATA_W    = 32
);
  logic                           flush_req;
  logic                           commit_stall;
  logic [NUM_UNITS-1:0]           unit_valid;
  logic [NUM_UNITS*TOKEN_W-1:0]   unit_token;
  logic [NUM_UNITS*5-1:0]         unit_rd_addr;
  logic [NUM_UNITS*DATA_W-1:0]    unit_rd_data;
  logic [NUM_UNITS-1:0]           unit_wb_en;
  logic [NUM_UNITS-1:0]           unit_ready;
  logic                           commit_valid;
  logic [4:0]                     commit_rd_addr;
  logic [DATA_W-1:0]              commit_rd_data;
  logic                           commit_wr_en;
  logic [31:0]                    commit_mask;
  logic [NUM_UNITS-1:0]           commit_unit;
  logic                           dup_token_err;

  modport master (
    output flush_req, commit_stall, unit_valid, unit_token,
           unit_rd_addr, unit_rd_data, unit_wb_en,
    input  unit_ready, commit_valid, commit_rd_addr, commit_rd_data,
           commit_wr_en, commit_mask, commit_unit, dup_token_err
  );

  modport slave (
    input  flush_req, commit_stall, unit_valid, unit_token,
           unit_rd_addr, unit_rd_data, unit_wb_en,
    output unit_ready, commit_valid, commit_rd_addr, commit_rd_data,
           commit_wr_en, commit_mask, commit_unit, dup_token_err
  );
endinterface

// File: rtl/hsv_core_commit_order.sv
// In-order commit arbiter: retires the unit result carrying the expected token.
// Optional duplicate-token detection is enabled by HSV_COMMIT_DUP_CHECK_EN.
module hsv_core_commit_order #(
  parameter int NUM_UNITS = 5,
  parameter int TOKEN_W   = 8,
  parameter int DATA_W    = 32
) (
  input logic                    clk_core,
  input logic                    rst_core_n,
  hsv_core_commit_order_if.slave bus
);
  logic [TOKEN_W-1:0]   expected_token_reg;
  logic [NUM_UNITS-1:0] match;
  logic [NUM_UNITS-1:0] win_oh;
  logic                 accept;
  logic [4:0]           win_rd_addr;
  logic [DATA_W-1:0]    win_rd_data;
  logic                 win_wb_en;
  logic                 win_wr_en;

  logic                 commit_valid_reg;
  logic [4:0]           commit_rd_addr_reg;
  logic [DATA_W-1:0]    commit_rd_data_reg;
  logic                 commit_wr_en_reg;
  logic [31:0]          commit_mask_reg;
  logic [NUM_UNITS-1:0] commit_unit_reg;

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_match
      assign match[gi] = bus.unit_valid[gi] &&
                         (bus.unit_token[gi*TOKEN_W +: TOKEN_W] == expected_token_reg);
    end
  endgenerate

  // Isolate the lowest set bit: lowest unit index wins a tie.
  assign win_oh = match & (~match + NUM_UNITS'(1));
  // Ready is gated by reset too, since the match path is purely combinational.
  assign accept = rst_core_n && (|match) && !bus.commit_stall && !bus.flush_req;
  assign bus.unit_ready = accept ? win_oh : '0;

  always_comb begin
    win_rd_addr = '0;
    win_rd_data = '0;
    win_wb_en   = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (win_oh[i]) begin
        win_rd_addr = bus.unit_rd_addr[i*5 +: 5];
        win_rd_data = bus.unit_rd_data[i*DATA_W +: DATA_W];
        win_wb_en   = bus.unit_wb_en[i];
      end
    end
  end

  assign win_wr_en = win_wb_en && (win_rd_addr != 5'd0);

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      expected_token_reg <= '0;
      commit_valid_reg   <= 1'b0;
      commit_rd_addr_reg <= '0;
      commit_rd_data_reg <= '0;
      commit_wr_en_reg   <= 1'b0;
      commit_mask_reg    <= '0;
      commit_unit_reg    <= '0;
    end else if (bus.flush_req) begin
      expected_token_reg <= '0;
      commit_valid_reg   <= 1'b0;
      commit_wr_en_reg   <= 1'b0;
      commit_mask_reg    <= '0;
    end else if (accept) begin
      expected_token_reg <= expected_token_reg + TOKEN_W'(1);
      commit_valid_reg   <= 1'b1;
      commit_rd_addr_reg <= win_rd_addr;
      commit_rd_data_reg <= win_rd_data;
      commit_wr_en_reg   <= win_wr_en;
      commit_mask_reg    <= win_wr_en ? (32'd1 << win_rd_addr) : 32'd0;
      commit_unit_reg    <= win_oh;
    end else begin
      // Payload fields hold; only the qualifiers drop.
      commit_valid_reg   <= 1'b0;
      commit_wr_en_reg   <= 1'b0;
      commit_mask_reg    <= '0;
    end
  end

  assign bus.commit_valid   = commit_valid_reg;
  assign bus.commit_rd_addr = commit_rd_addr_reg;
  assign bus.commit_rd_data = commit_rd_data_reg;
  assign bus.commit_wr_en   = commit_wr_en_reg;
  assign bus.commit_mask    = commit_mask_reg;
  assign bus.commit_unit    = commit_unit_reg;

`ifdef HSV_COMMIT_DUP_CHECK_EN
  logic dup_token_err_reg;
  logic multi_match;

  assign multi_match = |(match & (match - NUM_UNITS'(1)));

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      dup_token_err_reg <= 1'b0;
    end else if (multi_match) begin
      dup_token_err_reg <= 1'b1;
    end
  end

  assign bus.dup_token_err = dup_token_err_reg;
`else
  assign bus.dup_token_err = 1'b0;
`endif
endmodule

// File: tb/tb_hsv_core_commit_order.sv
// Self-checking bench for hsv_core_commit_order: directed scenarios plus
// randomized traffic against a token-order reference model.
module tb_hsv_core_commit_order;
  localparam int NU = 5;
  localparam int TW = 8;
  localparam int DW = 32;
  localparam int TOK_MOD = 1 << TW;

  logic clk_core   = 1'b0;
  logic rst_core_n = 1'b0;
  always #5 clk_core = ~clk_core;

  hsv_core_commit_order_if #(.NUM_UNITS(NU), .TOKEN_W(TW), .DATA_W(DW)) bus ();

  hsv_core_commit_order #(.NUM_UNITS(NU), .TOKEN_W(TW), .DATA_W(DW)) dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int          m_exp;
  logic        m_valid;
  logic        m_wr;
  logic [31:0] m_mask;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [NU-1:0] m_unit;
  logic        m_dup;

  function automatic int winner(input int e);
    for (int i = 0; i < NU; i++)
      if (bus.unit_valid[i] && int'(bus.unit_token[i*TW +: TW]) == e) return i;
    return -1;
  endfunction

  function automatic int n_match(input int e);
    int n = 0;
    for (int i = 0; i < NU; i++)
      if (bus.unit_valid[i] && int'(bus.unit_token[i*TW +: TW]) == e) n++;
    return n;
  endfunction

  function automatic logic [4:0] f_rd(input int i);
    return bus.unit_rd_addr[i*5 +: 5];
  endfunction

  function automatic logic [31:0] f_data(input int i);
    return bus.unit_rd_data[i*DW +: DW];
  endfunction

  function automatic logic f_wr(input int i);
    return bus.unit_wb_en[i] && (bus.unit_rd_addr[i*5 +: 5] != 5'd0);
  endfunction

  function automatic logic [NU-1:0] onehot(input int i);
    logic [NU-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NU-1:0] exp_ready();
    int w;
    if (!rst_core_n || bus.flush_req || bus.commit_stall) return '0;
    w = winner(m_exp);
    if (w < 0) return '0;
    return onehot(w);
  endfunction

  always @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      m_exp <= 0; m_valid <= 1'b0; m_wr <= 1'b0; m_mask <= '0;
      m_rd <= '0; m_data <= '0; m_unit <= '0; m_dup <= 1'b0;
    end else begin
      if (bus.flush_req) begin
        m_exp <= 0; m_valid <= 1'b0; m_wr <= 1'b0; m_mask <= '0;
      end else if (!bus.commit_stall && winner(m_exp) >= 0) begin
        m_valid <= 1'b1;
        m_rd    <= f_rd(winner(m_exp));
        m_data  <= f_data(winner(m_exp));
        m_wr    <= f_wr(winner(m_exp));
        m_mask  <= f_wr(winner(m_exp)) ? (32'd1 << f_rd(winner(m_exp))) : 32'd0;
        m_unit  <= onehot(winner(m_exp));
        m_exp   <= (m_exp + 1) % TOK_MOD;
      end else begin
        m_valid <= 1'b0; m_wr <= 1'b0; m_mask <= '0;
      end
`ifdef HSV_COMMIT_DUP_CHECK_EN
      if (n_match(m_exp) >= 2) m_dup <= 1'b1;
`endif
    end
  end

  // Single compare process: every cycle, away from the rising edge.
  always @(negedge clk_core) begin
    if (cmp_en) begin
      check("ready", bus.unit_ready, exp_ready());
      check("commit_valid", bus.commit_valid, m_valid);
      check("commit_wr_en", bus.commit_wr_en, m_wr);
      check("commit_mask", bus.commit_mask, m_mask);
      check("dup_token_err", bus.dup_token_err, m_dup);
      if (m_valid) begin
        check("commit_rd_addr", bus.commit_rd_addr, m_rd);
        check("commit_rd_data", bus.commit_rd_data, m_data);
        check("commit_unit", bus.commit_unit, m_unit);
        $display("commit unit=%b rd=%0d data=%h wr=%0d", bus.commit_unit,
                 bus.commit_rd_addr, bus.commit_rd_data, bus.commit_wr_en);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    bus.unit_valid   = '0;
    bus.unit_token   = '0;
    bus.unit_rd_addr = '0;
    bus.unit_rd_data = '0;
    bus.unit_wb_en   = '0;
    bus.flush_req    = 1'b0;
    bus.commit_stall = 1'b0;
  endtask

  task automatic set_unit(input int i, input int tok, input int rd, input logic [31:0] d, input logic wb);
    bus.unit_valid[i]              = 1'b1;
    bus.unit_token[i*TW +: TW]     = TW'(tok);
    bus.unit_rd_addr[i*5 +: 5]     = 5'(rd);
    bus.unit_rd_data[i*DW +: DW]   = d;
    bus.unit_wb_en[i]              = wb;
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_core);
  endtask

  task automatic do_flush();
    step(); idle(); bus.flush_req = 1'b1; sample();
  endtask

  // Commits tokens 0..n-1 on alu, starting right after a flush.
  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      step(); idle(); set_unit(0, k, k + 1, 32'h100 + 32'(k), 1'b1); sample();
    end
  endtask

  int ncommit;

  initial begin
    idle();
    rst_core_n = 1'b0;
    cmp_en = 1'b1;

    // Reset: a matching result must not be readied, outputs all zero.
    step(); set_unit(0, 0, 9, 32'hDEAD0000, 1'b1); sample();
    check("rst ready", bus.unit_ready, 5'b00000);
    check("rst valid", bus.commit_valid, 1'b0);
    check("rst data", bus.commit_rd_data, 32'h0);
    check("rst unit", bus.commit_unit, 5'b00000);
    step(); rst_core_n = 1'b1; sample();
    check("post-rst first accept", bus.unit_ready, 5'b00001);
    step(); idle(); sample();
    check("post-rst commit data", bus.commit_rd_data, 32'hDEAD0000);
    check("post-rst mask", bus.commit_mask, 32'h200);

    // Two units, consecutive tokens, same cycle: strict order.
    $display("scenario: in-order alu/mem");
    do_flush();
    step(); idle(); set_unit(0, 0, 3, 32'hA0, 1'b1); set_unit(2, 1, 4, 32'hB1, 1'b1); sample();
    check("order c0 ready", bus.unit_ready, 5'b00001);
    step(); idle(); set_unit(2, 1, 4, 32'hB1, 1'b1); sample();
    check("order c1 ready", bus.unit_ready, 5'b00100);
    check("order c1 unit", bus.commit_unit, 5'b00001);
    check("order c1 mask", bus.commit_mask, 32'h8);
    step(); idle(); sample();
    check("order c2 unit", bus.commit_unit, 5'b00100);
    check("order c2 data", bus.commit_rd_data, 32'hB1);
    step(); idle(); sample();
    check("order c3 valid", bus.commit_valid, 1'b0);

    // rd=0 with wb_en: commit but no regfile write.
    $display("scenario: branch rd0");
    do_flush();
    step(); idle(); set_unit(3, 0, 0, 32'hC0, 1'b1); sample();
    check("rd0 ready", bus.unit_ready, 5'b01000);
    step(); idle(); sample();
    check("rd0 valid", bus.commit_valid, 1'b1);
    check("rd0 wr_en", bus.commit_wr_en, 1'b0);
    check("rd0 mask", bus.commit_mask, 32'h0);

    // Stall holds the matching foo token 4.
    $display("scenario: stall");
    do_flush();
    advance(4);
    for (int s = 0; s < 3; s++) begin
      step(); idle(); set_unit(1, 4, 7, 32'hD4, 1'b1); bus.commit_stall = 1'b1; sample();
      check("stall ready", bus.unit_ready, 5'b00000);
      if (s >= 1) begin
        check("stall valid drop", bus.commit_valid, 1'b0);
        check("stall data hold", bus.commit_rd_data, 32'h103);
      end
    end
    step(); idle(); set_unit(1, 4, 7, 32'hD4, 1'b1); sample();
    check("unstall ready", bus.unit_ready, 5'b00010);
    step(); idle(); sample();
    check("unstall unit", bus.commit_unit, 5'b00010);

    // Flush overrides a match; stale token stays pending afterwards.
    $display("scenario: flush");
    do_flush();
    advance(7);
    step(); idle(); set_unit(2, 7, 5, 32'hE7, 1'b1); bus.flush_req = 1'b1; sample();
    check("flush ready", bus.unit_ready, 5'b00000);
    step(); idle(); set_unit(2, 7, 5, 32'hE7, 1'b1); sample();
    check("flush valid", bus.commit_valid, 1'b0);
    check("pending ready", bus.unit_ready, 5'b00000);
    step(); idle(); set_unit(2, 7, 5, 32'hE7, 1'b1); set_unit(4, 0, 6, 32'hF0, 1'b1); sample();
    check("flush token0", bus.unit_ready, 5'b10000);

    // 257 back-to-back alu commits across the token wrap.
    $display("scenario: wrap");
    do_flush();
    ncommit = 0;
    for (int k = 0; k < 257; k++) begin
      step(); idle(); set_unit(0, k % TOK_MOD, (k % 31) + 1, 32'(k), 1'b1); sample();
      if (k >= 1 && bus.commit_valid) ncommit++;
    end
    step(); idle(); sample();
    if (bus.commit_valid) ncommit++;
    check("wrap commits", 64'(ncommit), 64'd257);
    check("wrap last data", bus.commit_rd_data, 32'd256);

    // Simultaneous alu/ctrlstatus on token 3.
    $display("scenario: duplicate token");
    do_flush();
    advance(3);
    step(); idle(); set_unit(0, 3, 1, 32'h31, 1'b1); set_unit(4, 3, 2, 32'h32, 1'b1); sample();
    check("dup ready", bus.unit_ready, 5'b00001);
    for (int s = 0; s < 3; s++) begin
      step(); idle(); sample();
`ifdef HSV_COMMIT_DUP_CHECK_EN
      check("dup sticky", bus.dup_token_err, 1'b1);
`else
      check("dup tied", bus.dup_token_err, 1'b0);
`endif
    end

    // Reset mid-cycle abandons an acceptance in flight.
    $display("scenario: mid reset");
    do_flush();
    step(); idle(); set_unit(0, 0, 8, 32'h77, 1'b1); sample();
    check("midrst pre ready", bus.unit_ready, 5'b00001);
    #2 rst_core_n = 1'b0;
    #1;
    check("midrst ready", bus.unit_ready, 5'b00000);
    check("midrst dup", bus.dup_token_err, 1'b0);
    step(); sample();
    check("midrst valid", bus.commit_valid, 1'b0);
    step(); rst_core_n = 1'b1; sample();
    check("midrst first ready", bus.unit_ready, 5'b00001);
    step(); idle(); sample();
    check("midrst commit data", bus.commit_rd_data, 32'h77);

    // Randomized traffic against the model.
    $display("scenario: random");
    for (int c = 0; c < 3000; c++) begin
      step(); idle();
      rst_core_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NU; i++) begin
        if ($urandom_range(0, 2) == 0)
          set_unit(i, (m_exp + int'($urandom_range(0, 3))) % TOK_MOD,
                   int'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      end
      bus.commit_stall = ($urandom_range(0, 4) == 0);
      bus.flush_req    = ($urandom_range(0, 39) == 0);
      sample();
    end
    step(); idle(); rst_core_n = 1'b1; sample();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
